// File: rtl/demux_1_4_reg_if.sv
// Handshake bundle for demux_1_4_reg: one producer stream in, four registered
// consumer streams out, plus per-channel delivered-word counters.
interface demux_1_4_reg_if #(
   parameter int W  = 4,
   parameter int CW = 8
);
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_data;
   logic [1:0]    in_sel;
   logic [3:0]    out_valid;
   logic [3:0]    out_ready;
   logic [W-1:0]  d0;
   logic [W-1:0]  d1;
   logic [W-1:0]  d2;
   logic [W-1:0]  d3;
   logic [CW-1:0] cnt0;
   logic [CW-1:0] cnt1;
   logic [CW-1:0] cnt2;
   logic [CW-1:0] cnt3;

   modport master (
      output in_valid, in_data, in_sel, out_ready,
      input  in_ready, out_valid, d0, d1, d2, d3, cnt0, cnt1, cnt2, cnt3
   );

   modport slave (
      input  in_valid, in_data, in_sel, out_ready,
      output in_ready, out_valid, d0, d1, d2, d3, cnt0, cnt1, cnt2, cnt3
   );
endinterface

// File: rtl/demux_1_4_reg.sv
// Registered 1:4 stream demultiplexer: each channel is a one-entry slot
// (EMPTY/FULL) that can drain and reload in the same cycle without a bubble.
module demux_1_4_reg #(
   parameter int W  = 4,
   parameter int CW = 8
) (
   input  logic             clk,
   input  logic             rst,
   demux_1_4_reg_if.slave   bus
);
   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } slot_state_t;

   slot_state_t   r_state [4];
   slot_state_t   w_state_nxt [4];
   logic [W-1:0]  r_data [4];
   logic [CW-1:0] r_cnt [4];
   logic [3:0]    w_load;
   logic [3:0]    w_drain;
   logic          w_in_ready;
   logic          w_accept;

   // Handshake decode and per-slot next-state selection
   always_comb begin
      w_in_ready = 1'b0;
      w_accept   = 1'b0;
      w_load     = 4'b0000;
      w_drain    = 4'b0000;
      for (int k = 0; k < 4; k++) begin
         w_state_nxt[k] = r_state[k];
      end

      // A full slot can still accept when its consumer empties it this cycle
      w_in_ready = (r_state[bus.in_sel] == ST_EMPTY) || bus.out_ready[bus.in_sel];
      w_accept   = bus.in_valid && w_in_ready;

      for (int k = 0; k < 4; k++) begin
         w_load[k]  = w_accept && (bus.in_sel == 2'(k));
         w_drain[k] = (r_state[k] == ST_FULL) && bus.out_ready[k];
         case (r_state[k])
            ST_EMPTY: begin
               if (w_load[k]) begin
                  w_state_nxt[k] = ST_FULL;
               end else begin
                  w_state_nxt[k] = ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (w_load[k]) begin
                  w_state_nxt[k] = ST_FULL;
               end else if (w_drain[k]) begin
                  w_state_nxt[k] = ST_EMPTY;
               end else begin
                  w_state_nxt[k] = ST_FULL;
               end
            end
            default: begin
               w_state_nxt[k] = ST_EMPTY;
            end
         endcase
      end
   end

   // Slot state, data and delivered-word counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < 4; k++) begin
            r_state[k] <= ST_EMPTY;
            r_data[k]  <= {W{1'b0}};
            r_cnt[k]   <= {CW{1'b0}};
         end
      end else begin
         for (int k = 0; k < 4; k++) begin
            r_state[k] <= w_state_nxt[k];
            if (w_load[k]) begin
               r_data[k] <= bus.in_data;
            end
            if (w_drain[k]) begin
               r_cnt[k] <= r_cnt[k] + {{(CW-1){1'b0}}, 1'b1};
            end
         end
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = {r_state[3] == ST_FULL, r_state[2] == ST_FULL,
                           r_state[1] == ST_FULL, r_state[0] == ST_FULL};
   assign bus.d0        = r_data[0];
   assign bus.d1        = r_data[1];
   assign bus.d2        = r_data[2];
   assign bus.d3        = r_data[3];
   assign bus.cnt0      = r_cnt[0];
   assign bus.cnt1      = r_cnt[1];
   assign bus.cnt2      = r_cnt[2];
   assign bus.cnt3      = r_cnt[3];
endmodule

// File: tb/tb_demux_1_4_reg.sv
// Directed self-checking bench for demux_1_4_reg: routing, backpressure,
// same-cycle replace, streaming with counter wrap, parallel drain, async reset.
`timescale 1ns/1ps
module tb_demux_1_4_reg;
   logic clk;
   logic rst;
   int   tests;
   int   fails;

   demux_1_4_reg_if #(.W(4), .CW(8)) bus_if ();

   demux_1_4_reg #(.W(4), .CW(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach the summary, time=%0t", $time);
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus_if.in_valid  = 1'b0;
      bus_if.in_data   = 4'h0;
      bus_if.out_ready = 4'b0000;
      for (int s = 0; s < 4; s++) begin
         bus_if.in_sel = 2'(s);
         #1;
         tests++;
         if (bus_if.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready sel=%0d: got %b, want 1", s, bus_if.in_ready);
         end
      end
      tick();
      rst = 1'b0;
      tick();
      tests++;
      if (bus_if.out_valid !== 4'b0000 || {bus_if.d0, bus_if.d1, bus_if.d2, bus_if.d3} !== 16'h0000 ||
          {bus_if.cnt0, bus_if.cnt1, bus_if.cnt2, bus_if.cnt3} !== 32'h0) begin
         fails++;
         $display("FAIL reset_state: valid=%b d=%h%h%h%h cnt=%0d,%0d,%0d,%0d, want all zero",
                  bus_if.out_valid, bus_if.d0, bus_if.d1, bus_if.d2, bus_if.d3,
                  bus_if.cnt0, bus_if.cnt1, bus_if.cnt2, bus_if.cnt3);
      end
   endtask

   task automatic test_single_route();
      bus_if.in_data  = 4'hA;
      bus_if.in_sel   = 2'd2;
      bus_if.in_valid = 1'b1;
      tick();
      bus_if.in_valid = 1'b0;
      tests++;
      if (bus_if.out_valid !== 4'b0100 || bus_if.d2 !== 4'hA) begin
         fails++;
         $display("FAIL route_ch2: valid=%b d2=%h, want 0100 / a", bus_if.out_valid, bus_if.d2);
      end
      #1;
      tests++;
      if (bus_if.in_ready !== 1'b0) begin
         fails++;
         $display("FAIL ready_full_sel2: got %b, want 0", bus_if.in_ready);
      end
      bus_if.in_sel = 2'd0;
      #1;
      tests++;
      if (bus_if.in_ready !== 1'b1) begin
         fails++;
         $display("FAIL ready_empty_sel0: got %b, want 1", bus_if.in_ready);
      end
      bus_if.out_ready = 4'b0100;
      tick();
      bus_if.out_ready = 4'b0000;
      tests++;
      if (bus_if.out_valid !== 4'b0000 || bus_if.cnt2 !== 8'd1 || bus_if.d2 !== 4'hA) begin
         fails++;
         $display("FAIL drain_ch2: valid=%b cnt2=%0d d2=%h, want 0000 / 1 / a",
                  bus_if.out_valid, bus_if.cnt2, bus_if.d2);
      end
   endtask

   task automatic test_backpressure_replace();
      bus_if.in_data  = 4'h5;
      bus_if.in_sel   = 2'd1;
      bus_if.in_valid = 1'b1;
      tick();
      bus_if.in_data = 4'h6;
      #1;
      tests++;
      if (bus_if.in_ready !== 1'b0) begin
         fails++;
         $display("FAIL bp_ready: got %b, want 0", bus_if.in_ready);
      end
      tick();
      tests++;
      if (bus_if.d1 !== 4'h5 || bus_if.out_valid !== 4'b0010) begin
         fails++;
         $display("FAIL bp_hold: d1=%h valid=%b, want 5 / 0010", bus_if.d1, bus_if.out_valid);
      end
      bus_if.out_ready = 4'b0010;
      #1;
      tests++;
      if (bus_if.in_ready !== 1'b1) begin
         fails++;
         $display("FAIL replace_ready: got %b, want 1", bus_if.in_ready);
      end
      tick();
      bus_if.in_valid  = 1'b0;
      bus_if.out_ready = 4'b0000;
      tests++;
      if (bus_if.d1 !== 4'h6 || bus_if.out_valid !== 4'b0010 || bus_if.cnt1 !== 8'd1) begin
         fails++;
         $display("FAIL replace: d1=%h valid=%b cnt1=%0d, want 6 / 0010 / 1",
                  bus_if.d1, bus_if.out_valid, bus_if.cnt1);
      end
      bus_if.out_ready = 4'b0010;
      tick();
      bus_if.out_ready = 4'b0000;
      tests++;
      if (bus_if.out_valid !== 4'b0000 || bus_if.cnt1 !== 8'd2) begin
         fails++;
         $display("FAIL drain_ch1: valid=%b cnt1=%0d, want 0000 / 2", bus_if.out_valid, bus_if.cnt1);
      end
   endtask

   task automatic test_streaming();
      int bad_ready;
      int bad_data;
      logic [3:0] word;
      bad_ready = 0;
      bad_data  = 0;
      bus_if.in_sel    = 2'd3;
      bus_if.out_ready = 4'b1000;
      for (int i = 0; i < 300; i++) begin
         word = 4'((i * 7) + 3);
         bus_if.in_data  = word;
         bus_if.in_valid = 1'b1;
         #1;
         if (bus_if.in_ready !== 1'b1) bad_ready++;
         tick();
         if (bus_if.out_valid !== 4'b1000 || bus_if.d3 !== word) bad_data++;
      end
      bus_if.in_valid = 1'b0;
      tick();
      bus_if.out_ready = 4'b0000;
      tests++;
      if (bad_ready !== 0) begin
         fails++;
         $display("FAIL stream_ready: %0d cycles not ready, want 0", bad_ready);
      end
      tests++;
      if (bad_data !== 0) begin
         fails++;
         $display("FAIL stream_order: %0d wrong words on d3, want 0", bad_data);
      end
      tests++;
      if (bus_if.cnt3 !== 8'd44 || bus_if.out_valid !== 4'b0000) begin
         fails++;
         $display("FAIL stream_cnt3: cnt3=%0d valid=%b, want 44 / 0000", bus_if.cnt3, bus_if.out_valid);
      end
   endtask

   task automatic test_parallel_drain();
      for (int k = 0; k < 4; k++) begin
         bus_if.in_sel   = 2'(k);
         bus_if.in_data  = 4'(k + 1);
         bus_if.in_valid = 1'b1;
         tick();
      end
      bus_if.in_valid = 1'b0;
      tests++;
      if (bus_if.out_valid !== 4'b1111 || {bus_if.d3, bus_if.d2, bus_if.d1, bus_if.d0} !== 16'h4321) begin
         fails++;
         $display("FAIL fill_all: valid=%b d3..d0=%h%h%h%h, want 1111 / 4321",
                  bus_if.out_valid, bus_if.d3, bus_if.d2, bus_if.d1, bus_if.d0);
      end
      bus_if.out_ready = 4'b1111;
      tick();
      bus_if.out_ready = 4'b0000;
      tests++;
      if (bus_if.out_valid !== 4'b0000 ||
          {bus_if.cnt0, bus_if.cnt1, bus_if.cnt2, bus_if.cnt3} !== {8'd1, 8'd3, 8'd2, 8'd45}) begin
         fails++;
         $display("FAIL parallel_drain: valid=%b cnt=%0d,%0d,%0d,%0d, want 0000 / 1,3,2,45",
                  bus_if.out_valid, bus_if.cnt0, bus_if.cnt1, bus_if.cnt2, bus_if.cnt3);
      end
   endtask

   task automatic test_async_reset();
      for (int k = 0; k < 4; k++) begin
         bus_if.in_sel   = 2'(k);
         bus_if.in_data  = 4'(k + 7);
         bus_if.in_valid = 1'b1;
         tick();
      end
      bus_if.in_sel  = 2'd0;
      bus_if.in_data = 4'hC;
      @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      tests++;
      if (bus_if.out_valid !== 4'b0000 || {bus_if.d0, bus_if.d1, bus_if.d2, bus_if.d3} !== 16'h0000 ||
          {bus_if.cnt0, bus_if.cnt1, bus_if.cnt2, bus_if.cnt3} !== 32'h0) begin
         fails++;
         $display("FAIL async_clear: valid=%b d=%h%h%h%h cnt=%0d,%0d,%0d,%0d, want all zero before edge",
                  bus_if.out_valid, bus_if.d0, bus_if.d1, bus_if.d2, bus_if.d3,
                  bus_if.cnt0, bus_if.cnt1, bus_if.cnt2, bus_if.cnt3);
      end
      tick();
      tests++;
      if (bus_if.out_valid !== 4'b0000 || bus_if.d0 !== 4'h0) begin
         fails++;
         $display("FAIL accept_in_reset: valid=%b d0=%h, want 0000 / 0", bus_if.out_valid, bus_if.d0);
      end
      bus_if.in_valid = 1'b0;
      rst = 1'b0;
      tick();
      tests++;
      if (bus_if.out_valid !== 4'b0000) begin
         fails++;
         $display("FAIL post_reset_idle: valid=%b, want 0000", bus_if.out_valid);
      end
      bus_if.in_valid = 1'b1;
      bus_if.in_data  = 4'h3;
      tick();
      bus_if.in_valid = 1'b0;
      tests++;
      if (bus_if.out_valid !== 4'b0001 || bus_if.d0 !== 4'h3) begin
         fails++;
         $display("FAIL first_accept: valid=%b d0=%h, want 0001 / 3", bus_if.out_valid, bus_if.d0);
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      test_reset();
      test_single_route();
      test_backpressure_replace();
      test_streaming();
      test_parallel_drain();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
